// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
`default_nettype none

package instruction_fetch_pkg;

  localparam int DB_DEFAULT  = 16;
  localparam int OPW_DEFAULT = 5;

  localparam logic [OPW_DEFAULT-1:0] OP_HALT = 5'b00000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALTED = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_pc_unit.sv
// Program counter with clear, jump-load and increment, plus a range check.
`default_nettype none

module instruction_fetch_pc_unit #(
  parameter int AB        = 11,
  parameter int MEM_WORDS = 101
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic          inc_i,
  input  logic [AB-1:0] load_addr_i,
  output logic [AB-1:0] pc_o,
  output logic          out_of_range_o
);

  // One extra bit keeps the compare correct even if MEM_WORDS == 2**AB.
  localparam logic [AB:0] LIMIT = (AB+1)'(MEM_WORDS);

  logic [AB-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (clear_i)     pc_d = '0;
    else if (load_i) pc_d = load_addr_i;
    else if (inc_i)  pc_d = pc_q + AB'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc_o           = pc_q;
  assign out_of_range_o = ({1'b0, pc_q} >= LIMIT);

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// Fetch/sequencing stage: owns the PC, registers program words and issues
// them downstream over a valid/ready handshake; stops on HALT or bad address.
`default_nettype none

module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int AB        = 11,
  parameter int DB        = DB_DEFAULT,
  parameter int OPW       = OPW_DEFAULT,
  parameter int MEM_WORDS = 101,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          resume,
  output logic [AB-1:0] Addr,
  input  logic [DB-1:0] Data,
  output logic [DB-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          jump_en,
  input  logic [AB-1:0] jump_addr,
  output logic          halted,
  output logic          addr_error,
  output logic [CW-1:0] instr_count
);

  state_e        state_q, state_d;
  logic [DB-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          halted_q, halted_d;
  logic          err_q, err_d;
  logic [CW-1:0] count_q, count_d;

  logic          pc_clear, pc_load, pc_inc, out_of_range;
  logic [AB-1:0] pc;
  logic [OPW-1:0] opcode;

  assign opcode = Data[DB-1 -: OPW];

  instruction_fetch_pc_unit #(
    .AB        (AB),
    .MEM_WORDS (MEM_WORDS)
  ) u_pc (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (pc_clear),
    .load_i         (pc_load),
    .inc_i          (pc_inc),
    .load_addr_i    (jump_addr),
    .pc_o           (pc),
    .out_of_range_o (out_of_range)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    err_d    = err_q;
    count_d  = count_q;
    pc_clear = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          pc_clear = 1'b1;
        end
      end
      S_FETCH: begin
        // The range check wins so that an out-of-range word is never latched.
        if (out_of_range) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
          err_d    = 1'b1;
        end else if (opcode == OPW'(OP_HALT)) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
          instr_d  = Data;
          pc_inc   = 1'b1;
        end else begin
          state_d  = S_ISSUE;
          instr_d  = Data;
          valid_d  = 1'b1;
          pc_inc   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          state_d = S_FETCH;
          valid_d = 1'b0;
          count_d = (&count_q) ? count_q : count_q + CW'(1);
          pc_load = jump_en;
        end
      end
      S_HALTED: begin
        if (start) begin
          state_d  = S_FETCH;
          pc_clear = 1'b1;
          halted_d = 1'b0;
          err_d    = 1'b0;
        end else if (resume && !err_q) begin
          state_d  = S_FETCH;
          halted_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign Addr        = pc;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign addr_error  = err_q;
  assign instr_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch against a fixed memory image.
`default_nettype none

module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, resume;
  logic [10:0] Addr;
  logic [15:0] Data;
  logic [15:0] instr;
  logic        instr_valid, instr_ready;
  logic        jump_en;
  logic [10:0] jump_addr;
  logic        halted, addr_error;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:2047];
  logic [15:0] prog [0:6];
  int exp_cnt;

  always #5 clk = ~clk;

  assign Data = mem[Addr];

  instruction_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .resume      (resume),
    .Addr        (Addr),
    .Data        (Data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halted      (halted),
    .addr_error  (addr_error),
    .instr_count (instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1'b1; nclk(1); start = 1'b0;
  endtask

  task automatic pulse_resume;
    resume = 1'b1; nclk(1); resume = 1'b0;
  endtask

  // Resume from HALTED, expect one issued word, then the next HALT.
  task automatic run_one(input logic [15:0] exp_instr, input int stall, input logic [10:0] exp_pc);
    logic [10:0] held_pc;
    pulse_resume();
    nclk(1);
    chk("issue_instr", instr, exp_instr);
    chk("issue_valid", instr_valid, 1);
    held_pc = Addr;
    if (stall > 0) begin
      instr_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        nclk(1);
        chk("stall_valid", instr_valid, 1);
        chk("stall_instr", instr, exp_instr);
        chk("stall_pc", Addr, held_pc);
        chk("stall_count", instr_count, exp_cnt);
      end
      instr_ready = 1'b1;
    end
    nclk(1);
    exp_cnt++;
    chk("hs_valid", instr_valid, 0);
    chk("hs_count", instr_count, exp_cnt);
    nclk(1);
    chk("halt_flag", halted, 1);
    chk("halt_pc", Addr, exp_pc);
  endtask

  initial begin
    prog[0] = 16'h0801; prog[1] = 16'h1002; prog[2] = 16'h1803; prog[3] = 16'h2004;
    prog[4] = 16'h2805; prog[5] = 16'h3006; prog[6] = 16'h3807;
    for (int a = 0; a < 2048; a++) mem[a] = 16'h0000;
    for (int k = 0; 2 * k + 1 < 101; k++) mem[2 * k + 1] = prog[k % 7];

    rst_n = 1'b0; start = 1'b0; resume = 1'b0; instr_ready = 1'b1;
    jump_en = 1'b0; jump_addr = '0; exp_cnt = 0;
    nclk(2);
    chk("rst_pc", Addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", addr_error, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_instr", instr, 0);
    rst_n = 1'b1;
    nclk(1);

    // resume is ignored in IDLE
    pulse_resume();
    nclk(1);
    chk("idle_resume_halted", halted, 0);
    chk("idle_resume_valid", instr_valid, 0);
    chk("idle_resume_pc", Addr, 0);

    // Mem[0] is HALT
    pulse_start();
    chk("start_pc0", Addr, 0);
    nclk(1);
    chk("h0_halted", halted, 1);
    chk("h0_pc", Addr, 1);
    chk("h0_valid", instr_valid, 0);
    chk("h0_count", instr_count, 0);

    run_one(16'h0801, 0, 11'd3);
    run_one(16'h1002, 5, 11'd5);
    run_one(16'h1803, 0, 11'd7);
    run_one(16'h2004, 0, 11'd9);
    run_one(16'h2805, 0, 11'd11);
    run_one(16'h3006, 0, 11'd13);
    run_one(16'h3807, 0, 11'd15);
    nclk(3);
    chk("h14_halted", halted, 1);
    chk("h14_pc", Addr, 15);
    chk("h14_valid", instr_valid, 0);
    chk("h14_count", instr_count, 7);

    // Jump to 100 (a HALT word), then restart and jump to 101 (out of range)
    pulse_start();
    nclk(1);
    chk("j_h0_pc", Addr, 1);
    pulse_resume();
    nclk(1);
    chk("j_instr", instr, 16'h0801);
    jump_en = 1'b1; jump_addr = 11'd100;
    nclk(1);
    jump_en = 1'b0; exp_cnt++;
    chk("j100_pc", Addr, 100);
    chk("j100_count", instr_count, exp_cnt);
    nclk(1);
    chk("j100_halted", halted, 1);
    chk("j100_err", addr_error, 0);
    chk("j100_pc_after", Addr, 101);

    pulse_start();
    nclk(1);
    pulse_resume();
    nclk(1);
    jump_en = 1'b1; jump_addr = 11'd101;
    nclk(1);
    jump_en = 1'b0; exp_cnt++;
    chk("j101_pc", Addr, 101);
    nclk(1);
    chk("j101_halted", halted, 1);
    chk("j101_err", addr_error, 1);
    chk("j101_pc_hold", Addr, 101);
    pulse_resume();
    nclk(2);
    chk("err_resume_halted", halted, 1);
    chk("err_resume_err", addr_error, 1);
    chk("err_resume_pc", Addr, 101);
    pulse_start();
    chk("err_start_halted", halted, 0);
    chk("err_start_err", addr_error, 0);
    chk("err_start_pc", Addr, 0);
    nclk(1);
    chk("err_start_h0", Addr, 1);
    chk("err_start_count", instr_count, exp_cnt);

    // Asynchronous reset while an instruction is pending
    instr_ready = 1'b0;
    pulse_resume();
    nclk(1);
    chk("pre_rst_valid", instr_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_instr", instr, 0);
    chk("arst_pc", Addr, 0);
    chk("arst_count", instr_count, 0);
    chk("arst_halted", halted, 0);
    nclk(1);
    rst_n = 1'b1; instr_ready = 1'b1;
    nclk(1);

    // start and resume together in HALTED: start wins
    pulse_start();
    nclk(1);
    chk("sr_pre_pc", Addr, 1);
    start = 1'b1; resume = 1'b1;
    nclk(1);
    start = 1'b0; resume = 1'b0;
    chk("sr_pc", Addr, 0);
    chk("sr_halted", halted, 0);
    nclk(1);
    chk("sr_h0_pc", Addr, 1);
    chk("sr_h0_halted", halted, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
